otter_control_unit: RTL and testbench
=====================================

# otter_control_unit

Sequencing and decode block for the Otter RV32I MCU. It is the producer on the ALU's control interface: from the fetched instruction and the branch-condition flags it generates `ALU_FUN` and the operand-mux selects that feed the ALU. A multicycle FSM issues the PC, register-file, memory and CSR write/read strobes, and it takes interrupts between instructions.

## Interface
- No parameters.
- `CLK` in 1: rising-edge clock for all state.
- `RST` in 1: synchronous, active-high reset.
- `INSTR` in 32: current instruction from memory port 1; valid from EXEC onward.
- `BR_EQ`, `BR_LT`, `BR_LTU` in 1 each: rs1/rs2 comparison flags from the branch-condition generator.
- `INTR` in 1: interrupt pending, already masked by MIE.
- `PC_WE`, `RF_WE`, `MEM_RDEN1`, `MEM_RDEN2`, `MEM_WE2`, `CSR_WE`, `INT_TAKEN`, `MRET_EXEC` out 1 each: single-cycle strobes.
- `RST_OUT` out 1: PC reset.
- `ALU_FUN` out 4: ALU opcode.
- `ALU_SRCA` out 1: 0 = rs1, 1 = U-immediate.
- `ALU_SRCB` out 2: 0 = rs2, 1 = I-immediate, 2 = S-immediate, 3 = PC.
- `PC_SOURCE` out 3: 0 = PC+4, 1 = jalr, 2 = branch, 3 = jal, 4 = mtvec, 5 = mepc.
- `RF_WR_SEL` out 2: 0 = PC+4, 1 = CSR read data, 2 = memory dout2, 3 = ALU result.

## Operation
- **FSM states and transitions**
  - INIT → FETCH.
  - FETCH → EXEC.
  - EXEC → WB for LOAD. For all other opcodes, EXEC → INTR if `INTR` = 1, otherwise EXEC → FETCH.
  - WB → INTR if `INTR` = 1, otherwise WB → FETCH.
  - INTR → FETCH.
- **Strobes by state.** Any strobe not listed below is 0.
  - INIT: `RST_OUT` = 1.
  - FETCH: `MEM_RDEN1` = 1.
  - EXEC, LOAD: `MEM_RDEN2` = 1.
  - EXEC, STORE: `MEM_WE2` = 1 and `PC_WE` = 1.
  - EXEC, BRANCH: `PC_WE` = 1.
  - EXEC, LUI/AUIPC/JAL/JALR/OP/OP_IMM: `PC_WE` = 1 and `RF_WE` = 1.
  - EXEC, SYSTEM with funct3 = 001 (CSRRW): `PC_WE`, `RF_WE`, `CSR_WE` = 1; `RF_WR_SEL` = 1.
  - EXEC, SYSTEM with funct3 = 000 (MRET): `PC_WE` = 1, `MRET_EXEC` = 1, `PC_SOURCE` = 5.
  - WB: `RF_WE` = 1, `PC_WE` = 1, `RF_WR_SEL` = 2.
  - INTR: `INT_TAKEN` = 1, `PC_WE` = 1, `PC_SOURCE` = 4.
- **Unknown opcode** in EXEC: `PC_WE` = 1 only (executes as a NOP). `ALU_FUN` = 0000.
- **ALU_FUN encoding:** add 0000, sub 1000, or 0110, and 0111, xor 0100, srl 0101, sll 0001, sra 1101, slt 0010, sltu 0011, lui-copy 1001.
  - OP: {`INSTR[30]`, funct3}.
  - OP_IMM: {funct3 == 101 ? `INSTR[30]` : 0, funct3}. The ADDI encoding with bit 30 set must never produce sub.
  - LUI: 1001 with `ALU_SRCA` = 1.
  - AUIPC: 0000 with `ALU_SRCA` = 1, `ALU_SRCB` = 3.
  - LOAD / JALR: 0000 with `ALU_SRCB` = 1.
  - STORE: 0000 with `ALU_SRCB` = 2.
  - BRANCH / JAL: 0000.
- **RF_WR_SEL** per opcode: JAL/JALR 0, CSRRW 1, LOAD 2, all others 3.
- **Branch decision (PC_SOURCE)**
  - beq: `BR_EQ`; bne: !`BR_EQ`.
  - blt: `BR_LT`; bge: !`BR_LT`.
  - bltu: `BR_LTU`; bgeu: !`BR_LTU`.
  - Taken → 2, not taken → 0. funct3 010/011 → 0.
- `INTR` is sampled only at the end of EXEC (non-load) or at the end of WB. It is ignored in INIT, FETCH and INTR.

## Timing
- **Reset:** the state register is the only flop. `RST` = 1 at a rising edge forces INIT at that edge, from any state, including mid-load or mid-INTR.
- **Outputs after reset:** `RST_OUT` = 1; every other strobe = 0. Decode outputs (`ALU_FUN`, selects) are combinational from `INSTR` and have no reset value.
- **Holding RST** keeps the FSM in INIT. The first FETCH occurs one cycle after `RST` deasserts.
- **Strobe timing:** all strobes are combinational from state plus `INSTR`, valid within the state's cycle, and asserted for exactly one cycle per instruction.
- **Latency:** 2 cycles per instruction (FETCH, EXEC); loads take 3; a taken interrupt adds 1.

## Structure
- **Package `otter_pkg`:**
  - state enum {INIT, FETCH, EXEC, WB, INTR};
  - opcode constants: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011;
  - `ALU_FUN` codes;
  - `PC_SOURCE`, `ALU_SRCB` and `RF_WR_SEL` select codes. The ALU's own decode uses the same `ALU_FUN` codes.
- **Sub-module `otter_cu_decoder`** (purely combinational): `INSTR` + branch flags → `ALU_FUN`, `ALU_SRCA`, `ALU_SRCB`, `PC_SOURCE`, `RF_WR_SEL`.
- **Top level:** holds the FSM and the strobe generation, and overrides `PC_SOURCE` in INTR and for MRET.

## Test plan
- **Reset:** assert `RST` for 2 cycles during a load's WB. Required: next state INIT, `RST_OUT` = 1, `RF_WE` = 0; after release, FETCH with `MEM_RDEN1` = 1.
- **R-type sub:** `INSTR` = 0x40208033 (sub x0,x1,x2). Required in EXEC: `ALU_FUN` = 1000, `ALU_SRCB` = 0, `RF_WR_SEL` = 3, `RF_WE` = `PC_WE` = 1; next state FETCH.
- **srai / addi:** `INSTR` = 0x4030D093 (srai x1,x1,3) → `ALU_FUN` = 1101, `ALU_SRCB` = 1. Then `INSTR` = 0x40008093 → `ALU_FUN` = 0000.
- **Load:** `INSTR` = 0x0000A083 (lw). Required: EXEC `MEM_RDEN2` = 1, `ALU_SRCB` = 1, `RF_WE` = 0; WB `RF_WE` = 1, `RF_WR_SEL` = 2, `PC_WE` = 1.
- **Branch:** bne (0x00209463) with `BR_EQ` = 1 → `PC_SOURCE` = 0; with `BR_EQ` = 0 → `PC_SOURCE` = 2. For bgeu with `BR_LTU` = 0 → `PC_SOURCE` = 2.
- **Interrupt:** `INTR` = 1 during EXEC of addi. Required: next state INTR, `INT_TAKEN` = `PC_WE` = 1, `PC_SOURCE` = 4, then FETCH. Then MRET (0x30200073) → `MRET_EXEC` = 1, `PC_SOURCE` = 5.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared encodings for the Otter control unit: FSM states, opcodes,
// ALU function codes and datapath mux selects.
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b1001;

    localparam logic [2:0] PCS_PC4    = 3'd0;
    localparam logic [2:0] PCS_JALR   = 3'd1;
    localparam logic [2:0] PCS_BRANCH = 3'd2;
    localparam logic [2:0] PCS_JAL    = 3'd3;
    localparam logic [2:0] PCS_MTVEC  = 3'd4;
    localparam logic [2:0] PCS_MEPC   = 3'd5;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IIMM = 2'd1;
    localparam logic [1:0] SRCB_SIMM = 2'd2;
    localparam logic [1:0] SRCB_PC   = 2'd3;

    localparam logic [1:0] WRSEL_PC4 = 2'd0;
    localparam logic [1:0] WRSEL_CSR = 2'd1;
    localparam logic [1:0] WRSEL_MEM = 2'd2;
    localparam logic [1:0] WRSEL_ALU = 2'd3;

    // funct3 010/011 are not branch encodings and never redirect the PC.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/otter_cu_decoder.sv
// Combinational instruction decode: ALU opcode, operand selects, next-PC
// source and register write-back select.
module otter_cu_decoder
    import otter_pkg::*;
(
    input  logic [31:0] INSTR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_SRCA,
    output logic [1:0]  ALU_SRCB,
    output logic [2:0]  PC_SOURCE,
    output logic [1:0]  RF_WR_SEL
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       unused_bits_s;

    assign opcode_s      = INSTR[6:0];
    assign funct3_s      = INSTR[14:12];
    assign unused_bits_s = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};

    // Per-opcode decode of ALU controls, PC source and write-back source.
    always_comb begin
        ALU_FUN   = ALU_ADD;
        ALU_SRCA  = 1'b0;
        ALU_SRCB  = SRCB_RS2;
        PC_SOURCE = PCS_PC4;
        RF_WR_SEL = WRSEL_ALU;
        case (opcode_s)
            OPC_OP: ALU_FUN = {INSTR[30], funct3_s};
            OPC_OP_IMM: begin
                // bit 30 is part of the immediate except for shifts, so addi never becomes sub
                if (funct3_s == F3_SR) begin
                    ALU_FUN = {INSTR[30], funct3_s};
                end else begin
                    ALU_FUN = {1'b0, funct3_s};
                end
                ALU_SRCB = SRCB_IIMM;
            end
            OPC_LUI: begin
                ALU_FUN  = ALU_LUI;
                ALU_SRCA = 1'b1;
            end
            OPC_AUIPC: begin
                ALU_SRCA = 1'b1;
                ALU_SRCB = SRCB_PC;
            end
            OPC_LOAD: begin
                ALU_SRCB  = SRCB_IIMM;
                RF_WR_SEL = WRSEL_MEM;
            end
            OPC_STORE: ALU_SRCB = SRCB_SIMM;
            OPC_JAL: begin
                PC_SOURCE = PCS_JAL;
                RF_WR_SEL = WRSEL_PC4;
            end
            OPC_JALR: begin
                ALU_SRCB  = SRCB_IIMM;
                PC_SOURCE = PCS_JALR;
                RF_WR_SEL = WRSEL_PC4;
            end
            OPC_BRANCH: begin
                if (branch_taken(funct3_s, BR_EQ, BR_LT, BR_LTU)) begin
                    PC_SOURCE = PCS_BRANCH;
                end else begin
                    PC_SOURCE = PCS_PC4;
                end
            end
            OPC_SYSTEM: begin
                if (funct3_s == F3_CSRRW) begin
                    RF_WR_SEL = WRSEL_CSR;
                end else begin
                    RF_WR_SEL = WRSEL_ALU;
                end
            end
            default: ALU_FUN = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/otter_control_unit.sv
// Multicycle sequencer for the Otter MCU: FETCH/EXEC/WB/INTR FSM issuing
// single-cycle strobes, with decode delegated to otter_cu_decoder.
module otter_control_unit
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    input  logic        INTR,
    output logic        PC_WE,
    output logic        RF_WE,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic        CSR_WE,
    output logic        INT_TAKEN,
    output logic        MRET_EXEC,
    output logic        RST_OUT,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_SRCA,
    output logic [1:0]  ALU_SRCB,
    output logic [2:0]  PC_SOURCE,
    output logic [1:0]  RF_WR_SEL
);

    state_t     state_r;
    state_t     next_state_s;
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [2:0] dec_pc_source_s;
    logic [1:0] dec_rf_wr_sel_s;

    assign opcode_s = INSTR[6:0];
    assign funct3_s = INSTR[14:12];

    otter_cu_decoder u_decoder (
        .INSTR     (INSTR),
        .BR_EQ     (BR_EQ),
        .BR_LT     (BR_LT),
        .BR_LTU    (BR_LTU),
        .ALU_FUN   (ALU_FUN),
        .ALU_SRCA  (ALU_SRCA),
        .ALU_SRCB  (ALU_SRCB),
        .PC_SOURCE (dec_pc_source_s),
        .RF_WR_SEL (dec_rf_wr_sel_s)
    );

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; INTR is only looked at when an instruction retires.
    always_comb begin
        next_state_s = ST_INIT;
        case (state_r)
            ST_INIT:  next_state_s = ST_FETCH;
            ST_FETCH: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (opcode_s == OPC_LOAD) begin
                    next_state_s = ST_WB;
                end else if (INTR) begin
                    next_state_s = ST_INTR;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB: begin
                if (INTR) begin
                    next_state_s = ST_INTR;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_INTR:  next_state_s = ST_FETCH;
            default:  next_state_s = ST_INIT;
        endcase
    end

    // Strobe generation and PC source overrides for MRET and interrupt entry.
    always_comb begin
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        RST_OUT   = 1'b0;
        PC_SOURCE = dec_pc_source_s;
        RF_WR_SEL = dec_rf_wr_sel_s;
        case (state_r)
            ST_INIT:  RST_OUT   = 1'b1;
            ST_FETCH: MEM_RDEN1 = 1'b1;
            ST_EXEC: begin
                case (opcode_s)
                    OPC_LOAD: MEM_RDEN2 = 1'b1;
                    OPC_STORE: begin
                        MEM_WE2 = 1'b1;
                        PC_WE   = 1'b1;
                    end
                    OPC_BRANCH: PC_WE = 1'b1;
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: begin
                        PC_WE = 1'b1;
                        RF_WE = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        PC_WE = 1'b1;
                        case (funct3_s)
                            F3_CSRRW: begin
                                RF_WE     = 1'b1;
                                CSR_WE    = 1'b1;
                                RF_WR_SEL = WRSEL_CSR;
                            end
                            F3_MRET: begin
                                MRET_EXEC = 1'b1;
                                PC_SOURCE = PCS_MEPC;
                            end
                            default: PC_WE = 1'b1;
                        endcase
                    end
                    default: PC_WE = 1'b1;
                endcase
            end
            ST_WB: begin
                RF_WE     = 1'b1;
                PC_WE     = 1'b1;
                RF_WR_SEL = WRSEL_MEM;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WE     = 1'b1;
                PC_SOURCE = PCS_MTVEC;
            end
            default: RST_OUT = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_otter_control_unit.sv
// Scoreboard bench for otter_control_unit: per-cycle expectations derived
// from instruction semantics are queued by the driver and checked by a monitor.
module tb_otter_control_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] INSTR = 32'd0;
    logic        BR_EQ = 1'b0, BR_LT = 1'b0, BR_LTU = 1'b0, INTR = 1'b0;
    logic        PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE;
    logic        INT_TAKEN, MRET_EXEC, RST_OUT, ALU_SRCA;
    logic [3:0]  ALU_FUN;
    logic [1:0]  ALU_SRCB, RF_WR_SEL;
    logic [2:0]  PC_SOURCE;

    otter_control_unit dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .BR_EQ(BR_EQ), .BR_LT(BR_LT),
        .BR_LTU(BR_LTU), .INTR(INTR), .PC_WE(PC_WE), .RF_WE(RF_WE),
        .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
        .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC),
        .RST_OUT(RST_OUT), .ALU_FUN(ALU_FUN), .ALU_SRCA(ALU_SRCA),
        .ALU_SRCB(ALU_SRCB), .PC_SOURCE(PC_SOURCE), .RF_WR_SEL(RF_WR_SEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_out, rden1, rden2, we2, pc_we, rf_we, csr_we, int_taken, mret;
        logic       chk_dec;
        logic [3:0] fun;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] rfsel;
        logic       chk_pcs;
        logic [2:0] pcs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle_no = 0;

    function automatic exp_t blank();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // What an instruction must do during its execute cycle.
    function automatic exp_t exec_exp(input logic [31:0] ins, input logic eq,
                                      input logic lt, input logic ltu);
        exp_t e;
        logic [2:0] f3;
        logic taken;
        e = blank();
        f3 = ins[14:12];
        e.chk_dec = 1'b1;
        e.chk_pcs = 1'b1;
        e.pc_we   = 1'b1;
        e.rfsel   = 2'd3;
        case (ins[6:0])
            7'b0110011: begin e.rf_we = 1'b1; e.fun = {ins[30], f3}; end
            7'b0010011: begin
                e.rf_we = 1'b1; e.srcb = 2'd1;
                e.fun = (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3};
            end
            7'b0110111: begin e.rf_we = 1'b1; e.fun = 4'b1001; e.srca = 1'b1; end
            7'b0010111: begin e.rf_we = 1'b1; e.srca = 1'b1; e.srcb = 2'd3; end
            7'b1101111: begin e.rf_we = 1'b1; e.pcs = 3'd3; e.rfsel = 2'd0; end
            7'b1100111: begin e.rf_we = 1'b1; e.srcb = 2'd1; e.pcs = 3'd1; e.rfsel = 2'd0; end
            7'b1100011: begin
                case (f3)
                    3'd0: taken = eq;   3'd1: taken = !eq;
                    3'd4: taken = lt;   3'd5: taken = !lt;
                    3'd6: taken = ltu;  3'd7: taken = !ltu;
                    default: taken = 1'b0;
                endcase
                e.pcs = taken ? 3'd2 : 3'd0;
            end
            7'b0000011: begin e.pc_we = 1'b0; e.rden2 = 1'b1; e.srcb = 2'd1; e.rfsel = 2'd2; end
            7'b0100011: begin e.we2 = 1'b1; e.srcb = 2'd2; end
            7'b1110011: begin
                if (f3 == 3'b001) begin
                    e.rf_we = 1'b1; e.csr_we = 1'b1; e.rfsel = 2'd1;
                end else if (f3 == 3'b000) begin
                    e.mret = 1'b1; e.pcs = 3'd5;
                end
            end
            default: e.fun = 4'b0000;
        endcase
        return e;
    endfunction

    function automatic exp_t init_exp();
        exp_t e;
        e = blank();
        e.rst_out = 1'b1;
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic r, input logic irq);
        RST  = r;
        INTR = irq;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic after_reset(input int hold);
        for (int i = 1; i < hold; i++) cyc(init_exp(), 1'b1, rbit());
        cyc(init_exp(), 1'b0, rbit());
    endtask

    // rst_stage: 0 FETCH, 1 EXEC, 2 WB, 3 INTR entry; anything else means no reset.
    task automatic run_instr(input logic [31:0] ins, input logic eq, input logic lt,
                             input logic ltu, input logic irq, input int rst_stage,
                             input int hold);
        exp_t e;
        logic is_load;
        logic r;
        INSTR = ins; BR_EQ = eq; BR_LT = lt; BR_LTU = ltu;
        is_load = (ins[6:0] == 7'b0000011);
        e = blank(); e.rden1 = 1'b1;
        r = (rst_stage == 0);
        cyc(e, r, rbit());
        if (r) begin after_reset(hold); return; end
        e = exec_exp(ins, eq, lt, ltu);
        r = (rst_stage == 1);
        cyc(e, r, is_load ? rbit() : irq);
        if (r) begin after_reset(hold); return; end
        if (is_load) begin
            e = blank(); e.pc_we = 1'b1; e.rf_we = 1'b1;
            e.chk_dec = 1'b1; e.srcb = 2'd1; e.rfsel = 2'd2;
            r = (rst_stage == 2);
            cyc(e, r, irq);
            if (r) begin after_reset(hold); return; end
        end
        if (irq) begin
            e = blank(); e.int_taken = 1'b1; e.pc_we = 1'b1; e.chk_pcs = 1'b1; e.pcs = 3'd4;
            r = (rst_stage == 3);
            cyc(e, r, rbit());
            if (r) begin after_reset(hold); return; end
        end
    endtask

    // Monitor: each cycle with a queued expectation is compared mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        logic [8:0] act, want;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cycle_no++;
            act  = {RST_OUT, MEM_RDEN1, MEM_RDEN2, MEM_WE2, PC_WE, RF_WE, CSR_WE, INT_TAKEN, MRET_EXEC};
            want = {e.rst_out, e.rden1, e.rden2, e.we2, e.pc_we, e.rf_we, e.csr_we, e.int_taken, e.mret};
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL strobes cyc=%0d instr=%h got=%b want=%b", cycle_no, INSTR, act, want);
            end
            if (e.chk_dec) begin
                total++;
                if ({ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL} !== {e.fun, e.srca, e.srcb, e.rfsel}) begin
                    bad++;
                    $display("FAIL decode cyc=%0d instr=%h got fun=%b a=%b b=%0d wr=%0d want fun=%b a=%b b=%0d wr=%0d",
                             cycle_no, INSTR, ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL,
                             e.fun, e.srca, e.srcb, e.rfsel);
                end
            end
            if (e.chk_pcs) begin
                total++;
                if (PC_SOURCE !== e.pcs) begin
                    bad++;
                    $display("FAIL pc_source cyc=%0d instr=%h flags=%b%b%b got=%0d want=%0d",
                             cycle_no, INSTR, BR_EQ, BR_LT, BR_LTU, PC_SOURCE, e.pcs);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                             7'b0110011, 7'b1110011, 7'b0001111, 7'b1111111};

    initial begin
        logic [31:0] ins;
        int          stg;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        cyc(init_exp(), 1'b1, 1'b1);
        cyc(init_exp(), 1'b0, 1'b1);

        run_instr(32'h40208033, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // sub
        run_instr(32'h4030D093, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // srai
        run_instr(32'h40008093, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // addi with bit 30 set
        run_instr(32'h0000A083, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // lw
        run_instr(32'h0000A083, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2);   // lw, reset held 2 cycles in WB
        run_instr(32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);  // bne not taken
        run_instr(32'h00209463, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // bne taken
        run_instr(32'h0020F463, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // bgeu taken
        run_instr(32'h00108093, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);  // addi + interrupt
        run_instr(32'h30200073, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);  // mret
        run_instr(32'h00108093, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1);   // reset during INTR
        run_instr(32'h0000A083, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);  // lw + interrupt after WB

        for (int n = 0; n < 500; n++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 11)];
            stg = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(ins, rbit(), rbit(), rbit(), ($urandom_range(0, 3) == 0),
                      stg, int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge CLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
